// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding, default
// timing parameters and the control-output patterns for each pipeline action.
package pipe_ctrl_pkg;

  localparam int REG_W           = 5;
  localparam int DEF_INIT_CYCLES = 4;
  localparam int DEF_TIMEOUT     = 16;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FREEZE = 2'd2
  } state_t;

  // A flush loads a bubble (all control fields zero) into the named register.
  typedef struct packed {
    logic pc_wr;
    logic if_id_wr;
    logic id_ex_wr;
    logic ex_mem_wr;
    logic mem_wb_wr;
    logic if_id_flush;
    logic id_ex_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_INIT = '{pc_wr: 1'b0, if_id_wr: 1'b1, id_ex_wr: 1'b1,
                                  ex_mem_wr: 1'b1, mem_wb_wr: 1'b1,
                                  if_id_flush: 1'b1, id_ex_flush: 1'b1};

  localparam ctrl_t CTRL_FREEZE = '{pc_wr: 1'b0, if_id_wr: 1'b0, id_ex_wr: 1'b0,
                                    ex_mem_wr: 1'b0, mem_wb_wr: 1'b0,
                                    if_id_flush: 1'b0, id_ex_flush: 1'b0};

  localparam ctrl_t CTRL_FLUSH = '{pc_wr: 1'b1, if_id_wr: 1'b1, id_ex_wr: 1'b1,
                                   ex_mem_wr: 1'b1, mem_wb_wr: 1'b1,
                                   if_id_flush: 1'b1, id_ex_flush: 1'b1};

  // Hold PC and IF/ID for one cycle while a bubble enters ID/EX.
  localparam ctrl_t CTRL_STALL = '{pc_wr: 1'b0, if_id_wr: 1'b0, id_ex_wr: 1'b1,
                                   ex_mem_wr: 1'b1, mem_wb_wr: 1'b1,
                                   if_id_flush: 1'b0, id_ex_flush: 1'b1};

  localparam ctrl_t CTRL_NORMAL = '{pc_wr: 1'b1, if_id_wr: 1'b1, id_ex_wr: 1'b1,
                                    ex_mem_wr: 1'b1, mem_wb_wr: 1'b1,
                                    if_id_flush: 1'b0, id_ex_flush: 1'b0};

endpackage

// File: rtl/pipe_loaduse_det.sv
// Load-use hazard detector: the ID instruction reads the register a load in
// EXE is about to write. Register 0 is hard-wired and never a hazard.
module pipe_loaduse_det
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             exe_read_mem,
  input  logic [REG_W-1:0] exe_rt,
  output logic             load_use
);

  assign load_use = exe_read_mem && (exe_rt != '0) &&
                    ((id_uses_rs && (id_rs == exe_rt)) ||
                     (id_uses_rt && (id_rt == exe_rt)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: Mealy control outputs for init, memory freeze,
// branch flush and load-use stall, plus performance and timeout monitoring.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int INIT_CYCLES = DEF_INIT_CYCLES,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             exe_read_mem,
  input  logic [REG_W-1:0] exe_rt,
  input  logic             exe_branch_taken,
  input  logic             dm_busy,
  output logic             pc_wr,
  output logic             if_id_wr,
  output logic             id_ex_wr,
  output logic             ex_mem_wr,
  output logic             mem_wb_wr,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic [1:0]       state,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      flush_cnt,
  output logic             err_timeout
);

  localparam int INIT_W = $clog2(INIT_CYCLES + 1);
  localparam int BUSY_W = $clog2(TIMEOUT + 1);

  state_t            state_q;
  logic [INIT_W-1:0] init_cnt;
  logic [BUSY_W-1:0] busy_cnt;
  logic              load_use;
  logic              run_mode;
  ctrl_t             ctrl;

  pipe_loaduse_det u_loaduse (
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .exe_read_mem (exe_read_mem),
    .exe_rt       (exe_rt),
    .load_use     (load_use)
  );

  assign run_mode = (state_q != ST_INIT);

  // Controls depend only on state and live inputs; counters never feed them.
  always_comb begin
    // NOTE: assigning a default before any branch keeps this block latch-free.
    ctrl = CTRL_NORMAL;
    if (!run_mode)             ctrl = CTRL_INIT;
    else if (dm_busy)          ctrl = CTRL_FREEZE;
    else if (exe_branch_taken) ctrl = CTRL_FLUSH;
    else if (load_use)         ctrl = CTRL_STALL;
  end

  assign pc_wr       = ctrl.pc_wr;
  assign if_id_wr    = ctrl.if_id_wr;
  assign id_ex_wr    = ctrl.id_ex_wr;
  assign ex_mem_wr   = ctrl.ex_mem_wr;
  assign mem_wb_wr   = ctrl.mem_wb_wr;
  assign if_id_flush = ctrl.if_id_flush;
  assign id_ex_flush = ctrl.id_ex_flush;
  assign state       = state_q;

  // FSM: INIT runs a fixed number of clocks regardless of dm_busy.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) begin
      state_q  <= ST_INIT;
      init_cnt <= '0;
    end else begin
      unique case (state_q)
        ST_INIT: begin
          if (init_cnt == INIT_W'(INIT_CYCLES - 1)) state_q <= ST_RUN;
          else                                      init_cnt <= init_cnt + INIT_W'(1);
        end
        ST_RUN:    if (dm_busy)  state_q <= ST_FREEZE;
        ST_FREEZE: if (!dm_busy) state_q <= ST_RUN;
        default:   state_q <= ST_INIT;
      endcase
    end
  end

  // Busy run length saturates at TIMEOUT; the sticky flag sees it one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cnt    <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (run_mode && dm_busy) begin
        if (busy_cnt != BUSY_W'(TIMEOUT)) busy_cnt <= busy_cnt + BUSY_W'(1);
      end else begin
        busy_cnt <= '0;
      end
      if (busy_cnt == BUSY_W'(TIMEOUT)) err_timeout <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (run_mode && !ctrl.pc_wr && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 32'd1;
      if (run_mode && !dm_busy && exe_branch_taken && (flush_cnt != '1))
        flush_cnt <= flush_cnt + 32'd1;
    end
  end

endmodule
